// File: rtl/norm_pkg.sv
// -----------------------------------------------------------------------------
// norm_pkg
// Shared widths and pipeline-stage record types for the 64-bit normalizer.
// The exponent field width NORM_EXP_W fixes the stage records. The top-level
// EXP_W parameter must be left at this value.
// -----------------------------------------------------------------------------
package norm_pkg;

    localparam int MANT_W     = 64;
    localparam int CNT_W      = 6;
    localparam int NORM_EXP_W = 14;

    // Stage 1 record: captured operand plus the shift that stage 2 will apply.
    typedef struct packed {
        logic [MANT_W-1:0]     mant;
        logic [NORM_EXP_W-1:0] exp;
        logic [CNT_W-1:0]      cnt;
        logic                  nz;
    } norm_s1_t;

    // Stage 2 record: the normalized result as presented on the output port.
    typedef struct packed {
        logic [MANT_W-1:0]     mant;
        logic [NORM_EXP_W-1:0] exp;
        logic [CNT_W-1:0]      shift;
        logic                  zero;
    } norm_s2_t;

endpackage

// File: rtl/lzc_64.sv
// -----------------------------------------------------------------------------
// lzc_64
// Leading-zero counter for a 64-bit word.
//   data  : word to scan
//   cnt   : number of zeros above the most significant set bit
//           (meaningless when valid = 0)
//   valid : at least one bit of data is set
// -----------------------------------------------------------------------------
module lzc_64
    import norm_pkg::*;
(
    input  logic [MANT_W-1:0] data,
    output logic [CNT_W-1:0]  cnt,
    output logic              valid
);

    // Priority scan from the LSB upward, so the highest set bit is the last to win.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < MANT_W; i++) begin
            cnt = data[i] ? CNT_W'(MANT_W - 1 - i) : cnt;
        end
    end

    assign valid = |data;

endmodule

// File: rtl/norm_64_pipe.sv
// -----------------------------------------------------------------------------
// norm_64_pipe
// Two-stage valid/ready pipelined normalizer for 64-bit mantissas.
//
// Stage 1 counts leading zeros and registers the operand together with the
// shift to apply. Stage 2 left-shifts the mantissa so that bit 63 is set. It
// subtracts the shift from the exponent modulo 2^EXP_W.
//
// Ports
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset
//   in_valid  : input beat present
//   in_ready  : block accepts input this cycle (combinational)
//   in_mant   : unnormalized mantissa
//   in_exp    : signed exponent
//   out_valid : output beat present
//   out_ready : downstream accepts output
//   out_mant  : normalized mantissa
//   out_exp   : adjusted exponent
//   out_shift : applied left-shift amount
//   out_zero  : input mantissa was zero
//
// Build option
//   NORM_DENORM_CLAMP_EN : when defined, the block limits the shift so that the
//                          exponent never drops below EMIN. A clamped result
//                          stays subnormal.
// -----------------------------------------------------------------------------
module norm_64_pipe
    import norm_pkg::*;
#(
    parameter int EXP_W = NORM_EXP_W,
    parameter int EMIN  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic [CNT_W-1:0]  out_shift,
    output logic              out_zero
);

    norm_s1_t          s1_r;
    norm_s2_t          s2_r;
    logic              s1_valid_r;
    logic              s2_valid_r;
    logic              s1_adv_s;
    logic              s2_adv_s;
    logic [CNT_W-1:0]  lzc_cnt_s;
    logic              lzc_nz_s;
    logic [CNT_W-1:0]  shift_s;

    lzc_64 u_lzc (
        .data  (in_mant),
        .cnt   (lzc_cnt_s),
        .valid (lzc_nz_s)
    );

    // A stage may take new data when it is empty or when its content moves on.
    assign s2_adv_s = ~s2_valid_r | out_ready;
    assign s1_adv_s = ~s1_valid_r | s2_adv_s;
    assign in_ready = s1_adv_s;

`ifdef NORM_DENORM_CLAMP_EN
    // Two guard bits keep in_exp - cnt free of wraparound during the compare.
    localparam logic signed [EXP_W+1:0] EMIN_W = (EXP_W + 2)'(EMIN);
    logic signed [EXP_W+1:0] exp_wide_s;
    logic signed [EXP_W+1:0] diff_s;

    // Shift selection. If a full shift would take the exponent below EMIN,
    // the block shifts only down to EMIN, or not at all when in_exp <= EMIN.
    always_comb begin
        exp_wide_s = {{2{in_exp[EXP_W-1]}}, in_exp};
        diff_s     = exp_wide_s - {{(EXP_W + 2 - CNT_W){1'b0}}, lzc_cnt_s};
        if (lzc_nz_s && (diff_s < EMIN_W)) begin
            if (exp_wide_s > EMIN_W) begin
                shift_s = CNT_W'(exp_wide_s - EMIN_W);
            end else begin
                shift_s = '0;
            end
        end else begin
            shift_s = lzc_cnt_s;
        end
    end
`else
    // Shift selection: always the full leading-zero count.
    always_comb begin
        shift_s = lzc_cnt_s;
    end
`endif

    // Stage 1 register: capture operand, shift and nonzero flag on input handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_r <= 1'b0;
            s1_r       <= '0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_r.mant <= in_mant;
                s1_r.exp  <= in_exp;
                s1_r.cnt  <= shift_s;
                s1_r.nz   <= lzc_nz_s;
            end else begin
                s1_r <= s1_r;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
            s1_r       <= s1_r;
        end
    end

    // Stage 2 register: normalize into the output record and hold it under backpressure.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_valid_r <= 1'b0;
            s2_r       <= '0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                // The count means nothing for a zero mantissa, so nz forces a clean zero result.
                if (s1_r.nz) begin
                    s2_r.mant  <= s1_r.mant << s1_r.cnt;
                    s2_r.exp   <= s1_r.exp - {{(NORM_EXP_W - CNT_W){1'b0}}, s1_r.cnt};
                    s2_r.shift <= s1_r.cnt;
                    s2_r.zero  <= 1'b0;
                end else begin
                    s2_r.mant  <= '0;
                    s2_r.exp   <= '0;
                    s2_r.shift <= '0;
                    s2_r.zero  <= 1'b1;
                end
            end else begin
                s2_r <= s2_r;
            end
        end else begin
            s2_valid_r <= s2_valid_r;
            s2_r       <= s2_r;
        end
    end

    assign out_valid = s2_valid_r;
    assign out_mant  = s2_r.mant;
    assign out_exp   = s2_r.exp;
    assign out_shift = s2_r.shift;
    assign out_zero  = s2_r.zero;

endmodule

// File: tb/tb_norm_64_pipe.sv
// -----------------------------------------------------------------------------
// tb_norm_64_pipe
// Self-checking bench for norm_64_pipe. Accepted inputs are turned into
// expected beats by an arithmetic reference model and pushed into a queue. A
// negedge monitor pops the queue on every output handshake and checks that
// stalled outputs stay stable.
// -----------------------------------------------------------------------------
module tb_norm_64_pipe;

    localparam int EXP_W = 14;
    localparam int EMIN  = 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_mant;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_mant;
    logic [EXP_W-1:0] out_exp;
    logic [5:0]       out_shift;
    logic             out_zero;

    typedef struct packed {
        logic [63:0]      mant;
        logic [EXP_W-1:0] exp;
        logic [5:0]       shift;
        logic             zero;
    } beat_t;

    beat_t sb[$];
    beat_t held;
    bit    hold_pending = 1'b0;
    int    nerr = 0;
    int    nchk = 0;
    int    out_beats = 0;

    norm_64_pipe #(.EXP_W(EXP_W), .EMIN(EMIN)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_shift (out_shift),
        .out_zero  (out_zero)
    );

    always #5 clock = ~clock;

    // Reference: find the highest set bit and shift it to bit 63. The exponent
    // is computed in plain integers and then reduced to EXP_W bits.
    function automatic beat_t model(input logic [63:0] m, input logic [EXP_W-1:0] e);
        beat_t r;
        int    lz;
        int    sh;
        int    ev;
        r = '0;
        if (m == 64'd0) begin
            r.zero = 1'b1;
            return r;
        end
        lz = 0;
        while (m[63 - lz] == 1'b0) lz++;
        ev = int'($signed(e));
        sh = lz;
`ifdef NORM_DENORM_CLAMP_EN
        if (ev - lz < EMIN) sh = (ev > EMIN) ? ev - EMIN : 0;
`endif
        r.mant  = m << sh;
        r.exp   = EXP_W'(ev - sh);
        r.shift = 6'(sh);
        r.zero  = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        nchk++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Scoreboard monitor: stability under stall, in-order output compare, then input capture.
    always @(negedge clock) begin
        beat_t eb;
        if (!reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_mant", out_mant, held.mant);
                chk("hold_exp", 64'(out_exp), 64'(held.exp));
                chk("hold_shift", 64'(out_shift), 64'(held.shift));
                chk("hold_zero", 64'(out_zero), 64'(held.zero));
            end
            if (out_valid && out_ready) begin
                out_beats++;
                hold_pending = 1'b0;
                if (sb.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL unexpected_beat: got mant %h with no beat outstanding", out_mant);
                end else begin
                    eb = sb.pop_front();
                    chk("out_mant", out_mant, eb.mant);
                    chk("out_exp", 64'(out_exp), 64'(eb.exp));
                    chk("out_shift", 64'(out_shift), 64'(eb.shift));
                    chk("out_zero", 64'(out_zero), 64'(eb.zero));
                end
            end else if (out_valid) begin
                held = {out_mant, out_exp, out_shift, out_zero};
                hold_pending = 1'b1;
            end else begin
                hold_pending = 1'b0;
            end
            if (in_valid && in_ready) sb.push_back(model(in_mant, in_exp));
        end
    end

    // Present one beat and wait for it to be taken. Starts and ends at posedge+1.
    task automatic send(input logic [63:0] m, input logic [EXP_W-1:0] e, input bit want_ready);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_mant  = m;
        in_exp   = e;
        @(negedge clock);
        if (want_ready) chk("b2b_in_ready", 64'(in_ready), 64'd1);
        while (!in_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (!in_ready) begin
            nchk++;
            nerr++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // With an empty pipe and out_ready high, the beat just sent is due on the second negedge.
    task automatic check_direct(input string name, input logic [63:0] m, input logic [EXP_W-1:0] e,
                                input logic [5:0] sh, input logic z);
        @(negedge clock);
        chk({name, "_lat_early"}, 64'(out_valid), 64'd0);
        @(negedge clock);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_mant"}, out_mant, m);
        chk({name, "_exp"}, 64'(out_exp), 64'(e));
        chk({name, "_shift"}, 64'(out_shift), 64'(sh));
        chk({name, "_zero"}, 64'(out_zero), 64'(z));
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(negedge clock);
            guard++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0]      bp_m[4];
        logic [EXP_W-1:0] bp_e[4];
        int               acc;
        int               beats0;
        bit               was_ready;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_mant   = 64'd0;
        in_exp    = '0;
        out_ready = 1'b1;

        // Reset state.
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_mant", out_mant, 64'd0);
        chk("rst_out_exp", 64'(out_exp), 64'd0);
        chk("rst_out_shift", 64'(out_shift), 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed examples.
        send(64'h0000_0000_0001_0000, EXP_W'(100), 1'b0);
        check_direct("normal", 64'h8000_0000_0000_0000, EXP_W'(53), 6'd47, 1'b0);
        send(64'd0, EXP_W'(5), 1'b0);
        check_direct("zero", 64'd0, EXP_W'(0), 6'd0, 1'b1);
        send(64'h8000_0000_0000_0001, EXP_W'(77), 1'b0);
        check_direct("prenorm", 64'h8000_0000_0000_0001, EXP_W'(77), 6'd0, 1'b0);
        send(64'h0000_0000_0000_0100, EXP_W'(10), 1'b0);
`ifdef NORM_DENORM_CLAMP_EN
        check_direct("clamp", 64'h0000_0000_0002_0000, EXP_W'(1), 6'd9, 1'b0);
`else
        check_direct("noclamp", 64'h8000_0000_0000_0000, EXP_W'(-45), 6'd55, 1'b0);
`endif
        drain();

        // Back-to-back: one beat per cycle, no bubble.
        beats0 = out_beats;
        for (int k = 63; k >= 56; k--) send(64'd1 << k, EXP_W'(0), 1'b1);
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("b2b_consecutive", 64'(out_beats - beats0), 64'd8);
        @(posedge clock);
        #1;
        drain();

        // Backpressure: four beats offered while the output stalls for five cycles.
        for (int i = 0; i < 4; i++) begin
            bp_m[i] = {$urandom, $urandom} >> $urandom_range(0, 40);
            bp_e[i] = EXP_W'($urandom);
        end
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_mant  = bp_m[acc];
            in_exp   = bp_e[acc];
            @(negedge clock);
            was_ready = in_ready;
            @(posedge clock);
            #1;
            if (was_ready) acc++;
        end
        chk("bp_accepts", 64'(acc), 64'd2);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int i = acc; i < 4; i++) send(bp_m[i], bp_e[i], 1'b0);
        drain();

        // Reset mid-flight: two beats in the pipe are discarded.
        out_ready = 1'b0;
        send(64'h0000_00F0_0000_0000, EXP_W'(20), 1'b0);
        send(64'h0000_0000_0000_0003, EXP_W'(30), 1'b0);
        reset = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_mant", out_mant, 64'd0);
        chk("midrst_exp", 64'(out_exp), 64'd0);
        chk("midrst_shift", 64'(out_shift), 64'd0);
        chk("midrst_zero", 64'(out_zero), 64'd0);
        sb.delete();
        @(posedge clock);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk("post_rst_idle", 64'(out_valid), 64'd0);
        end
        @(posedge clock);
        #1;

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_mant   = {$urandom, $urandom} >> $urandom_range(0, 64);
            in_exp    = EXP_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clock);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
